// File: rtl/fetcher.sv
// Per-core instruction fetch unit: issues program-memory reads for the current PC,
// returns the instruction, and skips the memory round trip on a repeated PC.
module fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             invalidate,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [15:0]                      stall_cycles
);

  typedef enum logic [2:0] {
    CS_IDLE    = 3'b000,
    CS_FETCH   = 3'b001,
    CS_DECODE  = 3'b010,
    CS_REQUEST = 3'b011,
    CS_WAIT    = 3'b100,
    CS_EXECUTE = 3'b101,
    CS_UPDATE  = 3'b110,
    CS_DONE    = 3'b111
  } core_state_t;

  typedef enum logic [2:0] {
    F_IDLE     = 3'b000,
    F_FETCHING = 3'b001,
    F_FETCHED  = 3'b010
  } fetch_state_t;

  fetch_state_t                     r_state;
  logic                             r_valid;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] r_addr;
  logic [PROGRAM_MEM_DATA_BITS-1:0] r_instr;
  logic [15:0]                      r_stall;
  logic                             r_reuse_valid;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] r_reuse_pc;
  logic                             w_hit;

  assign w_hit = r_reuse_valid && (current_pc == r_reuse_pc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= F_IDLE;
      r_valid       <= 1'b0;
      r_addr        <= '0;
      r_instr       <= '0;
      r_stall       <= '0;
      r_reuse_valid <= 1'b0;
      r_reuse_pc    <= '0;
    end else begin
      case (r_state)
        F_IDLE: begin
          if (core_state == CS_FETCH) begin
            if (w_hit) begin
              r_state <= F_FETCHED;
            end else begin
              r_addr  <= current_pc;
              r_valid <= 1'b1;
              r_state <= F_FETCHING;
            end
          end
        end
        F_FETCHING: begin
          if (mem_read_ready) begin
            r_instr       <= mem_read_data;
            r_valid       <= 1'b0;
            r_reuse_pc    <= r_addr;
            r_reuse_valid <= 1'b1;
            r_state       <= F_FETCHED;
          end else if (r_stall != 16'hFFFF) begin
            r_stall <= r_stall + 16'd1;
          end
        end
        F_FETCHED: begin
          if (core_state == CS_DECODE) r_state <= F_IDLE;
        end
        default: r_state <= F_IDLE;
      endcase
      // Placed last so it overrides a same-edge capture's reuse_valid set.
      if (invalidate) r_reuse_valid <= 1'b0;
    end
  end

  assign mem_read_valid   = r_valid;
  assign mem_read_address = r_addr;
  assign fetcher_state    = r_state;
  assign instruction      = r_instr;
  assign stall_cycles     = r_stall;

endmodule

// File: tb/tb_fetcher.sv
// Bench for fetcher: table of fetch transactions with a scoreboard of expected
// instructions, plus hand-written saturation and mid-fetch reset sequences.
module tb_fetcher;

  localparam logic [2:0] C_IDLE = 3'b000, C_FETCH = 3'b001, C_DECODE = 3'b010,
                         C_WAIT = 3'b100, C_EXEC = 3'b101;
  localparam logic [2:0] S_IDLE = 3'b000, S_FETCHING = 3'b001, S_FETCHED = 3'b010;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  core_state = C_IDLE;
  logic [7:0]  current_pc = '0;
  logic        invalidate = 1'b0;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready = 1'b0;
  logic [15:0] mem_read_data = 16'hDEAD;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  logic [15:0] stall_cycles;

  fetcher #(.PROGRAM_MEM_ADDR_BITS(8), .PROGRAM_MEM_DATA_BITS(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .core_state       (core_state),
    .current_pc       (current_pc),
    .invalidate       (invalidate),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction),
    .stall_cycles     (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] data;
    int unsigned k;
    bit          inv_fetch;
    bit          inv_cap;
    bit          exp_hit;
  } vec_t;

  int unsigned  n_tests = 0;
  int unsigned  n_fail  = 0;
  logic [15:0]  sb_q[$];
  logic [15:0]  m_instr = '0;
  int unsigned  m_stall = 0;
  vec_t         vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_chk(input string name);
    logic [15:0] e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty at %0t", name, $time);
    end else begin
      e = sb_q.pop_front();
      chk(name, {16'h0, instruction}, {16'h0, e});
    end
  endtask

  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b);
    return (a + b > 32'd65535) ? 32'd65535 : a + b;
  endfunction

  // Called about 1 time unit after a rising edge with the DUT in F_IDLE.
  task automatic run_fetch(input vec_t v);
    core_state     = C_FETCH;
    current_pc     = v.pc;
    invalidate     = v.inv_fetch;
    mem_read_ready = 1'b0;
    mem_read_data  = 16'hDEAD;
    sb_q.push_back(v.exp_hit ? m_instr : v.data);
    @(posedge clk); #1;
    invalidate = 1'b0;
    core_state = C_WAIT;
    current_pc = ~v.pc;
    if (v.exp_hit) begin
      chk("hit_state", {29'h0, fetcher_state}, {29'h0, S_FETCHED});
      chk("hit_no_req", {31'h0, mem_read_valid}, 32'h0);
    end else begin
      chk("miss_state", {29'h0, fetcher_state}, {29'h0, S_FETCHING});
      chk("req_valid", {31'h0, mem_read_valid}, 32'h1);
      chk("req_addr", {24'h0, mem_read_address}, {24'h0, v.pc});
      for (int i = 1; i < int'(v.k); i++) begin
        @(posedge clk); #1;
        chk("req_hold_valid", {31'h0, mem_read_valid}, 32'h1);
        chk("req_hold_addr", {24'h0, mem_read_address}, {24'h0, v.pc});
      end
      mem_read_ready = 1'b1;
      mem_read_data  = v.data;
      invalidate     = v.inv_cap;
      @(posedge clk); #1;
      mem_read_ready = 1'b0;
      invalidate     = 1'b0;
      mem_read_data  = 16'hFFFF;
      m_instr        = v.data;
      m_stall        = sat_add(m_stall, v.k - 1);
      chk("cap_valid_drop", {31'h0, mem_read_valid}, 32'h0);
    end
    chk("fetched", {29'h0, fetcher_state}, {29'h0, S_FETCHED});
    pop_chk("instr");
    chk("stall", {16'h0, stall_cycles}, m_stall);
    // ready is not a capture outside F_FETCHING
    core_state     = C_EXEC;
    mem_read_ready = 1'b1;
    @(posedge clk); #1;
    chk("fetched_hold", {29'h0, fetcher_state}, {29'h0, S_FETCHED});
    chk("instr_hold", {16'h0, instruction}, {16'h0, m_instr});
    mem_read_ready = 1'b0;
    core_state     = C_DECODE;
    @(posedge clk); #1;
    chk("to_idle", {29'h0, fetcher_state}, {29'h0, S_IDLE});
    core_state     = C_IDLE;
    mem_read_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_ignores_ready", {29'h0, fetcher_state}, {29'h0, S_IDLE});
    chk("idle_no_req", {31'h0, mem_read_valid}, 32'h0);
    mem_read_ready = 1'b0;
  endtask

  initial begin
    //            pc     data      k  invF invC hit
    vecs[0]  = '{8'h05, 16'h3A21, 3, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h05, 16'h0000, 0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{8'h06, 16'h1234, 1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'h06, 16'h0000, 0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{8'h07, 16'h0F0F, 2, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{8'h07, 16'h5A5A, 1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{8'h07, 16'h0000, 0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{8'h08, 16'hABCD, 4, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{8'h07, 16'h7777, 1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{8'h07, 16'h0000, 0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{8'h07, 16'h2468, 2, 1'b0, 1'b0, 1'b0};

    // Reset held with FETCH applied
    reset      = 1'b0;
    core_state = C_FETCH;
    current_pc = 8'h05;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {29'h0, fetcher_state}, {29'h0, S_IDLE});
    chk("rst_valid", {31'h0, mem_read_valid}, 32'h0);
    chk("rst_addr", {24'h0, mem_read_address}, 32'h0);
    chk("rst_instr", {16'h0, instruction}, 32'h0);
    chk("rst_stall", {16'h0, stall_cycles}, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) run_fetch(vecs[i]);

    // Saturation: long miss on PC 0x20
    core_state = C_FETCH;
    current_pc = 8'h20;
    sb_q.push_back(16'hBEEF);
    @(posedge clk); #1;
    core_state = C_WAIT;
    chk("sat_req", {31'h0, mem_read_valid}, 32'h1);
    for (int i = 1; i <= 70000; i++) begin
      @(posedge clk); #1;
      m_stall = sat_add(m_stall, 1);
      if (i == 60000 || i == 65528 || i == 65529 || i == 70000)
        chk("sat_stall", {16'h0, stall_cycles}, m_stall);
    end
    chk("sat_ceiling", {16'h0, stall_cycles}, 32'h0000FFFF);
    chk("sat_addr_hold", {24'h0, mem_read_address}, 32'h20);
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hBEEF;
    @(posedge clk); #1;
    mem_read_ready = 1'b0;
    m_instr        = 16'hBEEF;
    chk("sat_fetched", {29'h0, fetcher_state}, {29'h0, S_FETCHED});
    pop_chk("sat_instr");
    chk("sat_stall_after", {16'h0, stall_cycles}, 32'h0000FFFF);
    core_state = C_DECODE;
    @(posedge clk); #1;
    core_state = C_IDLE;

    // Reset mid-fetch clears reuse buffer
    run_fetch('{8'h30, 16'h1111, 1, 1'b0, 1'b0, 1'b0});
    core_state = C_FETCH;
    current_pc = 8'h31;
    @(posedge clk); #1;
    core_state = C_WAIT;
    chk("mid_req", {31'h0, mem_read_valid}, 32'h1);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, mem_read_valid}, 32'h0);
    chk("mid_rst_state", {29'h0, fetcher_state}, {29'h0, S_IDLE});
    chk("mid_rst_instr", {16'h0, instruction}, 32'h0);
    chk("mid_rst_stall", {16'h0, stall_cycles}, 32'h0);
    @(posedge clk); #1;
    reset      = 1'b1;
    core_state = C_IDLE;
    m_instr    = '0;
    m_stall    = 0;
    run_fetch('{8'h30, 16'h2222, 2, 1'b0, 1'b0, 1'b0});

    chk("sb_empty", sb_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
